// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell and a carry flop process one operand bit per clock, LSB first.
// Operands are accepted and the result is delivered through valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, res, res_next;
    logic [CW-1:0]    cnt;
    logic             carry, carry_next, s, co_r;

    always_comb begin
        s          = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at res[0].
        res_next            = res >> 1;
        res_next[WIDTH-1]   = s;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = RUN;
            RUN:     if (cnt == LAST)  state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            co_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) co_r <= carry_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = res;
    assign co        = co_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake, latency, backpressure and reset,
// and a 1-bit instance for the single-RUN-edge corner.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, ci, co, busy;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, ci1, co1, busy1;
    logic [0:0] a1, b1, sum1;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .co(co1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operand set on the 8-bit instance and wait for out_valid; leaves the result in DONE.
    task automatic send8(input logic [7:0] va, input logic [7:0] vb, input logic vci, input string tag);
        int  lat;
        bit  rdy_seen;
        logic [8:0] exp;
        lat = 0;
        rdy_seen = 0;
        exp = {1'b0, va} + {1'b0, vb} + {8'd0, vci};
        @(negedge clk);
        check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; a = va; b = vb; ci = vci;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 lat++;
            if (in_ready) rdy_seen = 1;
            if (out_valid) break;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_in_ready_low"}, {31'd0, rdy_seen}, 32'd0);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
        check({tag, "_co"}, {31'd0, co}, {31'd0, exp[8]});
    endtask

    task automatic pop8(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_pop_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_pop_out_valid"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic send1(input logic va, input logic vb, input logic vci,
                         input logic es, input logic eco, input string tag);
        @(negedge clk);
        in_valid1 = 1'b1; a1 = va; b1 = vb; ci1 = vci;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        check({tag, "_busy"}, {31'd0, busy1}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, {31'd0, out_valid1}, 32'd1);
        check({tag, "_sum"}, {31'd0, sum1}, {31'd0, es});
        check({tag, "_co"}, {31'd0, co1}, {31'd0, eco});
        @(posedge clk);
        #1 check({tag, "_handoff"}, {31'd0, in_ready1}, 32'd1);
    endtask

    logic [7:0] ta [3] = '{8'h10, 8'hF0, 8'h7F};
    logic [7:0] tb [3] = '{8'h22, 8'h20, 8'h80};
    logic       tc [3] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] texp [3] = '{9'h033, 9'h110, 9'h100};
    int acc_cyc [3];

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = '0; b = '0; ci = 0;
        in_valid1 = 0; out_ready1 = 1; a1 = '0; b1 = '0; ci1 = 0;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum_co", {23'd0, co, sum}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send8(8'h5A, 8'h3C, 1'b0, "t5a3c");
        pop8("t5a3c");
        send8(8'hFF, 8'h01, 1'b0, "tff01");
        pop8("tff01");
        send8(8'hFF, 8'hFF, 1'b1, "tfff1");
        pop8("tfff1");

        // Backpressure: new operands offered while the result is held.
        send8(8'h12, 8'h34, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'hAA; b = 8'h55; ci = 1'b1;
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_result", {23'd0, co, sum}, 32'h046);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop8("bp");
        check("bp_sum_after_pop", {24'd0, sum}, 32'h46);

        // Asynchronous reset three RUN edges into an operation.
        @(negedge clk);
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; ci = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_sum_co", {23'd0, co, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send8(8'h01, 8'h01, 1'b0, "post_rst");
        pop8("post_rst");

        // Back-to-back with out_ready tied high.
        begin
            int idx, got, cyc;
            idx = 0; got = 0; cyc = 0;
            out_ready = 1'b1;
            while (got < 3 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (out_valid) begin
                    check("b2b_result", {23'd0, co, sum}, {23'd0, texp[got]});
                    got++;
                end
                if (in_ready && idx < 3) begin
                    in_valid = 1'b1; a = ta[idx]; b = tb[idx]; ci = tc[idx];
                    acc_cyc[idx] = cyc;
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            in_valid = 1'b0;
            check("b2b_count", got, 3);
            check("b2b_spacing1", acc_cyc[1] - acc_cyc[0], 10);
            check("b2b_spacing2", acc_cyc[2] - acc_cyc[1], 10);
            @(negedge clk);
            out_ready = 1'b0;
        end

        // Random sweep against a + b + ci.
        for (int i = 0; i < 8; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
            pop8("rand");
        end

        send1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "w1_111");
        send1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w1_000");
        send1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "w1_100");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
